// File: rtl/cursor_canvas_if.sv
// rtl/cursor_canvas_if.sv - cursor/clear inputs, VGA read path and status outputs of cursor_canvas
interface cursor_canvas_if;
  logic [9:0]  cX;
  logic [9:0]  cY;
  logic [1:0]  cl;
  logic        clear_req;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid;
  logic [11:0] rgb;
  logic        busy;
  logic        oor;
  logic [5:0]  tile_x;
  logic [5:0]  tile_y;

  modport master (
    output cX, cY, cl, clear_req, pix_x, pix_y, pix_valid,
    input  rgb, busy, oor, tile_x, tile_y
  );

  modport slave (
    input  cX, cY, cl, clear_req, pix_x, pix_y, pix_valid,
    output rgb, busy, oor, tile_x, tile_y
  );
endinterface

// File: rtl/cursor_canvas.sv
// rtl/cursor_canvas.sv - 64x48 tile canvas painted by the cursor, 2-cycle VGA read path; CURSOR_OVERLAY_EN adds a cursor outline
module cursor_canvas #(
  parameter int          H_TILES    = 64,
  parameter int          V_TILES    = 48,
  parameter logic [11:0] CURSOR_RGB = 12'hFFF
) (
  input logic           CLK,
  input logic           RESET,
  cursor_canvas_if.slave bus
);

  localparam logic [10:0] X_LIM    = 11'(10 * H_TILES);
  localparam logic [10:0] Y_LIM    = 11'(10 * V_TILES);
  localparam logic [11:0] CLR_LAST = 12'(H_TILES * V_TILES - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WRITE} state_t;

  // floor(p/10) by reciprocal multiply; exact over the whole 10-bit range
  function automatic logic [5:0] tile_of(input logic [9:0] p);
    return 6'((18'(p) * 18'd205) >> 11);
  endfunction

  function automatic logic [11:0] colour_of(input logic [1:0] c);
    case (c)
      2'd1:    return 12'h0FF;
      2'd2:    return 12'hF0F;
      2'd3:    return 12'hFF0;
      default: return 12'h000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [11:0] clr_addr_q, clr_addr_d;
  logic [9:0]  last_x_q, last_x_d, last_y_q, last_y_d;
  logic [1:0]  last_cl_q, last_cl_d;
  logic [5:0]  tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic        oor_q, oor_d;

  logic        we;
  logic [11:0] waddr;
  logic [1:0]  wdata;
  logic        change;
  logic        cur_inr;

  logic [1:0]  canvas_mem [0:4095];

  assign change  = (bus.cX != last_x_q) || (bus.cY != last_y_q) || (bus.cl != last_cl_q);
  assign cur_inr = ({1'b0, bus.cX} < X_LIM) && ({1'b0, bus.cY} < Y_LIM);

  // control state and last-processed cursor sample
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      last_cl_q  <= '0;
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      last_cl_q  <= last_cl_d;
      tile_x_q   <= tile_x_d;
      tile_y_q   <= tile_y_d;
      oor_q      <= oor_d;
    end
  end

  // next state and canvas write port: clear sweep, or one tile paint per cursor change
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    last_x_d   = last_x_q;
    last_y_d   = last_y_q;
    last_cl_d  = last_cl_q;
    tile_x_d   = tile_x_q;
    tile_y_d   = tile_y_q;
    oor_d      = oor_q;
    we         = 1'b0;
    waddr      = clr_addr_q;
    wdata      = 2'b00;
    case (state_q)
      S_CLEAR: begin
        we = 1'b1;
        if (clr_addr_q == CLR_LAST) state_d = S_IDLE;
        else                        clr_addr_d = clr_addr_q + 12'd1;
      end
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end else if (change) begin
          last_x_d  = bus.cX;
          last_y_d  = bus.cY;
          last_cl_d = bus.cl;
          tile_x_d  = tile_of(bus.cX);
          tile_y_d  = tile_of(bus.cY);
          oor_d     = !cur_inr;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        we      = !oor_q;
        waddr   = {tile_y_q, tile_x_q};
        wdata   = last_cl_q;
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // canvas write port
  always_ff @(posedge CLK) begin
    if (we) canvas_mem[waddr] <= wdata;
  end

  logic [5:0]  px_tile, py_tile;
  logic        pix_inr;
  logic        hit_s0;

  assign px_tile = tile_of(bus.pix_x);
  assign py_tile = tile_of(bus.pix_y);
  assign pix_inr = ({1'b0, bus.pix_x} < X_LIM) && ({1'b0, bus.pix_y} < Y_LIM);

`ifdef CURSOR_OVERLAY_EN
  logic [9:0] rx, ry;
  assign rx     = bus.pix_x - ({4'd0, px_tile} * 10'd10);
  assign ry     = bus.pix_y - ({4'd0, py_tile} * 10'd10);
  assign hit_s0 = pix_inr && !oor_q && (px_tile == tile_x_q) && (py_tile == tile_y_q) &&
                  ((rx == 10'd0) || (rx == 10'd9) || (ry == 10'd0) || (ry == 10'd9));
`else
  assign hit_s0 = 1'b0;
`endif

  logic [1:0]  rd_q;
  logic        v1_q, inr1_q, hit1_q;
  logic [11:0] rgb_q, rgb_d;

  // read port: a write to the same address this cycle is not visible until next read
  always_ff @(posedge CLK) begin
    rd_q <= canvas_mem[{py_tile, px_tile}];
  end

  // stage-1 qualifiers travelling alongside the RAM read
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v1_q   <= 1'b0;
      inr1_q <= 1'b0;
      hit1_q <= 1'b0;
    end else begin
      v1_q   <= bus.pix_valid;
      inr1_q <= pix_inr;
      hit1_q <= hit_s0;
    end
  end

  always_comb begin
    rgb_d = 12'h000;
    if (v1_q && inr1_q) rgb_d = hit1_q ? CURSOR_RGB : colour_of(rd_q);
  end

  // stage-2 colour register
  always_ff @(posedge CLK) begin
    if (RESET) rgb_q <= 12'h000;
    else       rgb_q <= rgb_d;
  end

  assign bus.rgb    = rgb_q;
  assign bus.busy   = (state_q == S_CLEAR);
  assign bus.oor    = oor_q;
  assign bus.tile_x = tile_x_q;
  assign bus.tile_y = tile_y_q;

endmodule

// File: tb/tb_cursor_canvas.sv
// tb/tb_cursor_canvas.sv - directed self-checking bench for cursor_canvas
module tb_cursor_canvas;
  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  cursor_canvas_if bus();

  cursor_canvas dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic read_pix(input logic [9:0] x, input logic [9:0] y, input logic v,
                          output logic [11:0] val);
    bus.pix_x     = x;
    bus.pix_y     = y;
    bus.pix_valid = v;
    @(negedge CLK);
    @(negedge CLK);
    val = bus.rgb;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 5000) begin
      cnt++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    int cnt;
    logic [11:0] v;
    bus.cX = 0; bus.cY = 0; bus.cl = 0; bus.clear_req = 0;
    bus.pix_x = 0; bus.pix_y = 0; bus.pix_valid = 0;
    RESET = 1'b1;
    tick(3);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.oor !== 1'b0) begin n_bad++; $display("FAIL reset_oor: got %b want 0", bus.oor); end
    n_cmp++; if (bus.tile_x !== 6'd0 || bus.tile_y !== 6'd0) begin n_bad++; $display("FAIL reset_tile: got %0d,%0d want 0,0", bus.tile_x, bus.tile_y); end
    n_cmp++; if (bus.rgb !== 12'h000) begin n_bad++; $display("FAIL reset_rgb: got %h want 000", bus.rgb); end
    RESET = 1'b0;
    count_busy(cnt);
    n_cmp++; if (cnt != 3072) begin n_bad++; $display("FAIL reset_clear_len: got %0d want 3072", cnt); end
    read_pix(10'd5, 10'd5, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL reset_pix55: got %h want 000", v); end
  endtask

  task automatic test_paint;
    logic [11:0] v;
    bus.cX = 30; bus.cY = 20; bus.cl = 1;
    tick(3);
    n_cmp++; if (bus.tile_x !== 6'd3 || bus.tile_y !== 6'd2) begin n_bad++; $display("FAIL paint_tile: got %0d,%0d want 3,2", bus.tile_x, bus.tile_y); end
    n_cmp++; if (bus.oor !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL paint_flags: got oor=%b busy=%b want 0,0", bus.oor, bus.busy); end
    read_pix(10'd35, 10'd27, 1'b1, v);
    n_cmp++; if (v !== 12'h0FF) begin n_bad++; $display("FAIL paint_pix35_27: got %h want 0FF", v); end
    read_pix(10'd45, 10'd27, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL paint_pix45_27: got %h want 000", v); end
    read_pix(10'd40, 10'd27, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL paint_pix40_27: got %h want 000", v); end
    read_pix(10'd29, 10'd27, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL paint_pix29_27: got %h want 000", v); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] v;
    bus.cl = 2;
    @(negedge CLK);
    bus.pix_x = 35; bus.pix_y = 27; bus.pix_valid = 1'b1;
    bus.clear_req = 1'b1;
    @(negedge CLK);
    bus.clear_req = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL write_clear_drop: got busy=%b want 0", bus.busy); end
    @(negedge CLK);
    n_cmp++; if (bus.rgb !== 12'h0FF) begin n_bad++; $display("FAIL rdw_old: got %h want 0FF", bus.rgb); end
    read_pix(10'd35, 10'd27, 1'b1, v);
    n_cmp++; if (v !== 12'hF0F) begin n_bad++; $display("FAIL rdw_new: got %h want F0F", v); end
  endtask

  task automatic test_oor;
    logic [11:0] v;
    bus.cX = 1014; bus.cY = 20; bus.cl = 2;
    tick(3);
    n_cmp++; if (bus.oor !== 1'b1) begin n_bad++; $display("FAIL oor_flag: got %b want 1", bus.oor); end
    read_pix(10'd375, 10'd25, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL oor_alias_tile: got %h want 000", v); end
    read_pix(10'd634, 10'd5, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL oor_pix634_5: got %h want 000", v); end
    read_pix(10'd35, 10'd27, 1'b1, v);
    n_cmp++; if (v !== 12'hF0F) begin n_bad++; $display("FAIL oor_keep: got %h want F0F", v); end
  endtask

  task automatic test_clear_priority;
    int cnt;
    logic [11:0] v;
    bus.cX = 30; bus.cY = 20; bus.cl = 2;
    tick(3);
    bus.cX = 40; bus.cl = 3; bus.clear_req = 1'b1;
    @(negedge CLK);
    bus.clear_req = 1'b0;
    count_busy(cnt);
    n_cmp++; if (cnt != 3072) begin n_bad++; $display("FAIL clrpri_len: got %0d want 3072", cnt); end
    tick(3);
    n_cmp++; if (bus.tile_x !== 6'd4 || bus.oor !== 1'b0) begin n_bad++; $display("FAIL clrpri_tile: got x=%0d oor=%b want 4,0", bus.tile_x, bus.oor); end
    read_pix(10'd45, 10'd25, 1'b1, v);
    n_cmp++; if (v !== 12'hFF0) begin n_bad++; $display("FAIL clrpri_pix45_25: got %h want FF0", v); end
    read_pix(10'd35, 10'd25, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL clrpri_pix35_25: got %h want 000", v); end
  endtask

  task automatic test_pix_valid;
    logic [11:0] v;
    read_pix(10'd45, 10'd25, 1'b0, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL pv_invalid: got %h want 000", v); end
    read_pix(10'd700, 10'd25, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL pv_x_out: got %h want 000", v); end
    read_pix(10'd45, 10'd500, 1'b1, v);
    n_cmp++; if (v !== 12'h000) begin n_bad++; $display("FAIL pv_y_out: got %h want 000", v); end
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    logic [11:0] v;
    bus.clear_req = 1'b1;
    @(negedge CLK);
    bus.clear_req = 1'b0;
    tick(1000);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midclr_busy: got %b want 1", bus.busy); end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    count_busy(cnt);
    n_cmp++; if (cnt != 3072) begin n_bad++; $display("FAIL midclr_len: got %0d want 3072", cnt); end
    tick(3);
    read_pix(10'd45, 10'd25, 1'b1, v);
    n_cmp++; if (v !== 12'hFF0) begin n_bad++; $display("FAIL midclr_repaint: got %h want FF0", v); end
  endtask

  task automatic test_overlay;
    logic [11:0] v;
    bus.cX = 30; bus.cY = 20; bus.cl = 1;
    tick(3);
`ifdef CURSOR_OVERLAY_EN
    read_pix(10'd30, 10'd24, 1'b1, v);
    n_cmp++; if (v !== 12'hFFF) begin n_bad++; $display("FAIL ovl_left: got %h want FFF", v); end
    read_pix(10'd39, 10'd24, 1'b1, v);
    n_cmp++; if (v !== 12'hFFF) begin n_bad++; $display("FAIL ovl_right: got %h want FFF", v); end
    read_pix(10'd34, 10'd24, 1'b1, v);
    n_cmp++; if (v !== 12'h0FF) begin n_bad++; $display("FAIL ovl_inner: got %h want 0FF", v); end
`else
    read_pix(10'd30, 10'd24, 1'b1, v);
    n_cmp++; if (v !== 12'h0FF) begin n_bad++; $display("FAIL noovl_edge: got %h want 0FF", v); end
    read_pix(10'd34, 10'd24, 1'b1, v);
    n_cmp++; if (v !== 12'h0FF) begin n_bad++; $display("FAIL noovl_inner: got %h want 0FF", v); end
`endif
  endtask

  initial begin
    test_reset;
    test_paint;
    test_back_to_back;
    test_oor;
    test_clear_priority;
    test_pix_valid;
    test_reset_mid_clear;
    test_overlay;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
